bram_port_master: RTL and testbench

- Initiator for one port of the team's dual-port byte BRAM. It drives en/we/addr/din and captures dout, which is valid one clock after a read strobe.
- Arbitrates two sources onto that port:
  - a CPU-side single-byte request/acknowledge channel;
  - a block-fill engine used to clear or initialise video and scratch RAM.
- Sits between the bus glue and any BRAM instance.

---
 rtl/bram_master_pkg.sv | 21 ++
 rtl/bram_port_master_if.sv | 42 ++++
 rtl/bram_fill_ctr.sv | 45 ++++
 rtl/bram_port_master.sv | 110 +++++++++++
 tb/tb_bram_port_master.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_master_pkg.sv
// rtl/bram_master_pkg.sv - shared constants and state type for the BRAM port master
package bram_master_pkg;

  localparam int DEFAULT_AW = 16;
  localparam int RD_LATENCY = 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_ACK     = 3'd3;
  localparam logic [2:0] S_FILL    = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = S_IDLE,
    ST_ISSUE   = S_ISSUE,
    ST_RD_WAIT = S_RD_WAIT,
    ST_ACK     = S_ACK,
    ST_FILL    = S_FILL
  } state_t;

endpackage

// File: rtl/bram_port_master_if.sv
// rtl/bram_port_master_if.sv - CPU, block-fill and BRAM port signal bundle
interface bram_port_master_if
  import bram_master_pkg::*;
#(
  parameter int AW = DEFAULT_AW
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          cpu_ack;
  logic [7:0]    cpu_rdata;
  logic          fill_start;
  logic [AW-1:0] fill_base;
  logic [AW-1:0] fill_len;
  logic [7:0]    fill_value;
  logic          fill_busy;
  logic          fill_done;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic [7:0]    mem_dout;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  fill_start, fill_base, fill_len, fill_value,
    output fill_busy, fill_done,
    output mem_en, mem_we, mem_addr, mem_din,
    input  mem_dout
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output fill_start, fill_base, fill_len, fill_value,
    input  fill_busy, fill_done,
    input  mem_en, mem_we, mem_addr, mem_din,
    output mem_dout
  );
endinterface

// File: rtl/bram_fill_ctr.sv
// rtl/bram_fill_ctr.sv - block-fill address generator and remaining-byte counter
module bram_fill_ctr
  import bram_master_pkg::*;
#(
  parameter int AW = DEFAULT_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          advance,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] len,
  output logic [AW-1:0] addr,
  output logic          last,
  output logic          busy
);

  localparam logic [AW-1:0] ONE = AW'(1);

  logic [AW-1:0] remaining;

  // addr runs one ahead of the write on the bus; remaining counts writes still
  // to come after the current one, so zero marks the final beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
      busy      <= 1'b0;
    end else if (load) begin
      addr      <= base + ONE;
      remaining <= len;
      busy      <= 1'b1;
    end else if (advance && busy) begin
      if (remaining == '0) begin
        busy <= 1'b0;
      end else begin
        addr      <= addr + ONE;
        remaining <= remaining - ONE;
      end
    end
  end

  assign last = busy && (remaining == '0);

endmodule

// File: rtl/bram_port_master.sv
// rtl/bram_port_master.sv - arbitrates CPU byte accesses and block fills onto one BRAM port
module bram_port_master
  import bram_master_pkg::*;
#(
  parameter int AW = DEFAULT_AW
) (
  input  logic               clk,
  input  logic               rst_n,
  bram_port_master_if.master bus
);

  localparam logic [1:0] RD_CNT_LAST = 2'(RD_LATENCY - 1);

  state_t        state;
  logic [1:0]    rd_cnt;
  logic [AW-1:0] ctr_addr;
  logic          ctr_last;
  logic          ctr_busy;
  logic          ctr_load;
  logic          fill_step;

  assign ctr_load  = (state == ST_IDLE) && bus.fill_start;
  assign fill_step = (state == ST_FILL);

  bram_fill_ctr #(.AW(AW)) u_fill_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (ctr_load),
    .advance (fill_step),
    .base    (bus.fill_base),
    .len     (bus.fill_len),
    .addr    (ctr_addr),
    .last    (ctr_last),
    .busy    (ctr_busy)
  );

  assign bus.fill_busy = ctr_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      rd_cnt        <= '0;
      bus.cpu_ack   <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.fill_done <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_din   <= '0;
    end else begin
      bus.cpu_ack   <= 1'b0;
      bus.fill_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Fill takes priority; a concurrent CPU request stays pending.
          if (bus.fill_start) begin
            bus.mem_en   <= 1'b1;
            bus.mem_we   <= 1'b1;
            bus.mem_addr <= bus.fill_base;
            bus.mem_din  <= bus.fill_value;
            state        <= ST_FILL;
          end else if (bus.cpu_req) begin
            bus.mem_en   <= 1'b1;
            bus.mem_we   <= bus.cpu_we;
            bus.mem_addr <= bus.cpu_addr;
            bus.mem_din  <= bus.cpu_wdata;
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
          rd_cnt     <= '0;
          if (bus.mem_we) begin
            bus.cpu_ack <= 1'b1;
            state       <= ST_ACK;
          end else begin
            state <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (rd_cnt == RD_CNT_LAST) begin
            bus.cpu_rdata <= bus.mem_dout;
            bus.cpu_ack   <= 1'b1;
            state         <= ST_ACK;
          end else begin
            rd_cnt <= rd_cnt + 2'd1;
          end
        end
        ST_ACK: begin
          state <= ST_IDLE;
        end
        ST_FILL: begin
          if (ctr_last) begin
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.fill_done <= 1'b1;
            state         <= ST_IDLE;
          end else begin
            bus.mem_addr <= ctr_addr;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_port_master.sv
// tb/tb_bram_port_master.sv - self-checking bench for bram_port_master
module tb_bram_port_master;

  localparam int AW    = 16;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;
    int          exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bram_port_master_if #(.AW(AW)) bus ();

  bram_port_master #(.AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  function automatic logic [7:0] init_byte(input int i);
    return 8'(i * 7 + 3) ^ 8'(i >> 8);
  endfunction

  logic [7:0] bram [DEPTH];
  logic [7:0] model_mem [DEPTH];
  logic       bram_init = 1'b0;

  always @(posedge clk) begin
    if (!bram_init) begin
      for (int i = 0; i < DEPTH; i++) bram[i] <= init_byte(i);
      bram_init <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) bram[bus.mem_addr] <= bus.mem_din;
      else            bus.mem_dout <= bram[bus.mem_addr];
    end
  end

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] last_rd = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in an idle cycle; returns in the cycle where cpu_ack is seen.
  task automatic cpu_op(input string name, input logic we, input logic [15:0] addr,
                        input logic [7:0] wdata, input logic [7:0] exp_rdata, input int exp_lat);
    int lat, en_cnt, bad;
    logic [7:0] rd;
    lat = -1; en_cnt = 0; bad = 0; rd = 8'h00;
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      tick();
      if (bus.mem_en) begin
        en_cnt++;
        if (bus.mem_we !== we || bus.mem_addr !== addr || (we && bus.mem_din !== wdata)) bad++;
      end
      if (bus.cpu_ack) begin
        lat = cyc;
        rd  = bus.cpu_rdata;
        break;
      end
    end
    bus.cpu_req = 1'b0;
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    check({name, "_en_count"}, 32'(en_cnt), 32'd1);
    check({name, "_bus_beat"}, 32'(bad), 32'd0);
    check({name, "_rdata"}, 32'(rd), 32'(exp_rdata));
    if (we) model_mem[addr] = wdata;
    else    last_rd = exp_rdata;
  endtask

  // Entered in an idle cycle; returns in the idle cycle after fill_done.
  task automatic fill_op(input string name, input logic [15:0] base, input logic [15:0] len,
                         input logic [7:0] value, input int restart_cyc);
    int writes, done_cyc, bad, budget;
    writes = 0; done_cyc = -1; bad = 0; budget = int'(len) + 12;
    bus.fill_start = 1'b1; bus.fill_base = base; bus.fill_len = len; bus.fill_value = value;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      tick();
      bus.fill_start = (cyc == restart_cyc);
      if (cyc == restart_cyc) begin
        bus.fill_base  = base + 16'h0010;
        bus.fill_len   = 16'h0007;
        bus.fill_value = ~value;
      end
      if (bus.mem_en) begin
        if (!bus.mem_we || bus.mem_addr !== AW'(int'(base) + writes) ||
            bus.mem_din !== value || !bus.fill_busy) bad++;
        writes++;
      end
      if (bus.cpu_ack) bad++;
      if (bus.fill_done) begin
        done_cyc = cyc;
        if (bus.fill_busy) bad++;
        break;
      end
    end
    bus.fill_start = 1'b0;
    tick();
    if (bus.fill_done || bus.fill_busy || bus.mem_en) bad++;
    check({name, "_writes"}, 32'(writes), 32'(int'(len) + 1));
    check({name, "_done_cyc"}, 32'(done_cyc), 32'(int'(len) + 2));
    check({name, "_beats"}, 32'(bad), 32'd0);
    for (int i = 0; i <= int'(len); i++) model_mem[AW'(int'(base) + i)] = value;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t       vecs [9];
    int         writes, done_cyc, bad, rd_en_cyc, ack_cyc, cnt, op;
    logic [7:0] rd;
    logic [15:0] a, flen;

    vecs[0] = '{1'b1, 16'h1234, 8'hA5, 8'h00, 2};
    vecs[1] = '{1'b0, 16'h1234, 8'h00, 8'hA5, 3};
    vecs[2] = '{1'b1, 16'hFFFF, 8'h3C, 8'hA5, 2};
    vecs[3] = '{1'b0, 16'hFFFF, 8'h00, 8'h3C, 3};
    vecs[4] = '{1'b1, 16'h0000, 8'hC3, 8'h3C, 2};
    vecs[5] = '{1'b0, 16'h0000, 8'h00, 8'hC3, 3};
    vecs[6] = '{1'b0, 16'h1234, 8'h00, 8'hA5, 3};
    vecs[7] = '{1'b1, 16'h1234, 8'h00, 8'hA5, 2};
    vecs[8] = '{1'b0, 16'h1234, 8'h00, 8'h00, 3};

    for (int i = 0; i < DEPTH; i++) model_mem[i] = init_byte(i);
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.fill_start = 1'b0; bus.fill_base = '0; bus.fill_len = '0; bus.fill_value = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", 32'({bus.cpu_ack, bus.fill_busy, bus.fill_done, bus.mem_en, bus.mem_we}), 32'd0);
    check("reset_data", {bus.mem_addr, bus.mem_din, bus.cpu_rdata}, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      cpu_op($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_rdata, vecs[i].exp_lat);
      tick();
      check($sformatf("vec%0d_ack_pulse", i), 32'(bus.cpu_ack), 32'd0);
    end

    for (int i = 0; i < 4; i++) begin
      cpu_op($sformatf("pre%0d", i), 1'b1, 16'(i), 8'(8'h10 + i), last_rd, 2);
      tick();
    end
    for (int i = 0; i < 4; i++)
      cpu_op($sformatf("b2b%0d", i), 1'b0, 16'(i), 8'h00, 8'(8'h10 + i), (i == 0) ? 3 : 4);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.cpu_ack || bus.mem_en) cnt++;
    end
    check("b2b_no_extra_ack", 32'(cnt), 32'd0);

    fill_op("fill_wrap", 16'hFFF0, 16'h001F, 8'h00, 0);
    cpu_op("wrap_below", 1'b0, 16'hFFEF, 8'h00, init_byte(16'hFFEF), 3);
    tick();
    cpu_op("wrap_above", 1'b0, 16'h0010, 8'h00, init_byte(16'h0010), 3);
    tick();
    cpu_op("wrap_first", 1'b0, 16'h0000, 8'h00, 8'h00, 3);
    tick();

    fill_op("fill_len0", 16'h0040, 16'h0000, 8'hE1, 0);
    fill_op("fill_restart", 16'h0060, 16'h0007, 8'h42, 2);

    bus.fill_start = 1'b1; bus.fill_base = 16'h0004; bus.fill_len = 16'h0003; bus.fill_value = 8'h3C;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0005;
    writes = 0; bad = 0; done_cyc = -1; rd_en_cyc = -1; ack_cyc = -1; rd = 8'h00;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      tick();
      bus.fill_start = 1'b0;
      if (bus.mem_en && bus.mem_we) writes++;
      if (bus.mem_en && !bus.mem_we) begin
        if (rd_en_cyc < 0) rd_en_cyc = cyc;
        else bad++;
      end
      if (bus.fill_done) done_cyc = cyc;
      if (bus.cpu_ack) begin
        ack_cyc = cyc;
        rd = bus.cpu_rdata;
        break;
      end
    end
    bus.cpu_req = 1'b0;
    for (int i = 4; i < 8; i++) model_mem[i] = 8'h3C;
    last_rd = 8'h3C;
    check("cont_fill_writes", 32'(writes), 32'd4);
    check("cont_done_cyc", 32'(done_cyc), 32'd5);
    check("cont_read_en_cyc", 32'(rd_en_cyc), 32'd6);
    check("cont_ack_cyc", 32'(ack_cyc), 32'd8);
    check("cont_rdata", 32'(rd), 32'h3C);
    check("cont_dup_read", 32'(bad), 32'd0);
    tick();

    bus.fill_start = 1'b1; bus.fill_base = 16'h2000; bus.fill_len = 16'h000F; bus.fill_value = 8'h77;
    tick();
    bus.fill_start = 1'b0;
    tick();
    tick();
    check("rstfill_write3", 32'({bus.mem_en, bus.mem_we, bus.mem_addr}), 32'h3_2002);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstfill_ctrl", 32'({bus.cpu_ack, bus.fill_busy, bus.fill_done, bus.mem_en, bus.mem_we}), 32'd0);
    check("rstfill_data", {bus.mem_addr, bus.mem_din, bus.cpu_rdata}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_rd = 8'h00;
    model_mem[16'h2000] = 8'h77;
    model_mem[16'h2001] = 8'h77;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.fill_done || bus.fill_busy || bus.mem_en) cnt++;
    end
    check("rstfill_no_done", 32'(cnt), 32'd0);
    cpu_op("rstfill_rd0", 1'b0, 16'h2000, 8'h00, 8'h77, 3);
    tick();
    cpu_op("rstfill_rd2", 1'b0, 16'h2002, 8'h00, init_byte(16'h2002), 3);
    tick();

    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, 3));
      a  = 16'(32'hFFE0 + $urandom_range(0, 63));
      if (op == 0) begin
        cpu_op($sformatf("rnd%0d_wr", n), 1'b1, a, 8'($urandom), last_rd, 2);
        tick();
      end else if (op == 3) begin
        flen = 16'($urandom_range(0, 20));
        fill_op($sformatf("rnd%0d_fill", n), a, flen, 8'($urandom), 0);
      end else begin
        cpu_op($sformatf("rnd%0d_rd", n), 1'b0, a, 8'h00, model_mem[a], 3);
        tick();
      end
    end

    repeat (2) tick();
    cnt = 0;
    for (int i = 0; i < DEPTH; i++) if (bram[i] !== model_mem[i]) cnt++;
    check("final_mem_image", 32'(cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
